// File: rtl/pfg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pfg_pkg : shared types and constants for the pattern frame generator |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FRONT,
        ACTIVE,
        HBLANK,
        VBLANK
    } pfg_state_t;

    typedef enum logic [1:0] {
        PAT_HRAMP,
        PAT_VRAMP,
        PAT_CHECK,
        PAT_CONST
    } pfg_pattern_t;

    localparam int FRAME_CNT_W = 16;

    // Counter width for a count of n states; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pfg_pixel_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pfg_pixel_gen : combinational test-pattern pixel select from (x,y)   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pfg_pixel_gen
    import pfg_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int X_W    = 10,
    parameter int Y_W    = 9
) (
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    input  logic [1:0]        pattern,
    input  logic [DATA_W-1:0] const_val,
    output logic [DATA_W-1:0] pixel
);

    logic [DATA_W-1:0] w_x_pix;
    logic [DATA_W-1:0] w_y_pix;

    // Ramps wrap at the pixel width, so both coordinates are resized to it.
    assign w_x_pix = DATA_W'(x);
    assign w_y_pix = DATA_W'(y);

    always_comb begin
        pixel = '0;
        case (pfg_pattern_t'(pattern))
            PAT_HRAMP: pixel = w_x_pix;
            PAT_VRAMP: pixel = w_y_pix;
            PAT_CHECK: pixel = (w_x_pix[3] ^ w_y_pix[3]) ? '1 : '0;
            PAT_CONST: pixel = const_val;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pattern_frame_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pattern_frame_gen : sensor-style test pattern source with LV/FV      |
// | timing. Optional macro PFG_STAMP_EN stamps frame_cnt on pixel (0,0). |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pattern_frame_gen
    import pfg_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 800,
    parameter int FV_LEAD  = 4
) (
    input  logic                   sig_clock,
    input  logic                   sig_reset_n,
    input  logic                   sig_en_i,
    input  logic [1:0]             cfg_pattern,
    input  logic [DATA_W-1:0]      cfg_const,
    output logic [DATA_W-1:0]      odata,
    output logic                   oLValid,
    output logic                   oFValid,
    output logic                   sig_en_o,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int c_x_w   = cnt_width(H_ACTIVE);
    localparam int c_y_w   = cnt_width(V_ACTIVE);
    localparam int c_b_max = (H_BLANK > V_BLANK) ?
                             ((H_BLANK > FV_LEAD) ? H_BLANK : FV_LEAD) :
                             ((V_BLANK > FV_LEAD) ? V_BLANK : FV_LEAD);
    localparam int c_b_w   = cnt_width(c_b_max);

    localparam logic [c_x_w-1:0] c_x_last     = c_x_w'(H_ACTIVE - 1);
    localparam logic [c_y_w-1:0] c_y_last     = c_y_w'(V_ACTIVE - 1);
    localparam logic [c_b_w-1:0] c_front_last = c_b_w'(FV_LEAD - 1);
    localparam logic [c_b_w-1:0] c_hb_last    = c_b_w'(H_BLANK - 1);
    localparam logic [c_b_w-1:0] c_vb_last    = c_b_w'(V_BLANK - 1);

    pfg_state_t r_state;
    pfg_state_t w_next_state;

    logic [c_x_w-1:0]       r_x;
    logic [c_y_w-1:0]       r_y;
    logic [c_b_w-1:0]       r_b;
    logic [1:0]             r_pattern;
    logic [DATA_W-1:0]      r_const;

    logic [DATA_W-1:0]      r_odata;
    logic                   r_lv;
    logic                   r_fv;
    logic                   r_busy;
    logic                   r_done;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;

    logic                   w_x_last;
    logic                   w_y_last;
    logic                   w_front_last;
    logic                   w_hb_last;
    logic                   w_vb_last;
    logic                   w_lv;
    logic                   w_fv;
    logic                   w_busy;
    logic                   w_frame_end;
    logic [DATA_W-1:0]      w_pat_pixel;
    logic [DATA_W-1:0]      w_pixel;
    logic [DATA_W-1:0]      w_odata;

    assign w_x_last     = (r_x == c_x_last);
    assign w_y_last     = (r_y == c_y_last);
    assign w_front_last = (r_b == c_front_last);
    assign w_hb_last    = (r_b == c_hb_last);
    assign w_vb_last    = (r_b == c_vb_last);

    always_ff @(posedge sig_clock or negedge sig_reset_n) begin
        if (!sig_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_lv         = 1'b0;
        w_fv         = 1'b0;
        w_busy       = (r_state != IDLE);
        // First VBLANK cycle: FV drops on the next edge, so the frame is done.
        w_frame_end  = (r_state == VBLANK) && (r_b == '0);
        case (r_state)
            IDLE: begin
                if (sig_en_i) w_next_state = FRONT;
            end
            FRONT: begin
                w_fv = 1'b1;
                if (w_front_last) w_next_state = ACTIVE;
            end
            ACTIVE: begin
                w_fv = 1'b1;
                w_lv = 1'b1;
                if (w_x_last) w_next_state = w_y_last ? VBLANK : HBLANK;
            end
            HBLANK: begin
                w_fv = 1'b1;
                if (w_hb_last) w_next_state = ACTIVE;
            end
            VBLANK: begin
                if (w_vb_last) w_next_state = sig_en_i ? FRONT : IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge sig_clock or negedge sig_reset_n) begin
        if (!sig_reset_n) begin
            r_x       <= '0;
            r_y       <= '0;
            r_b       <= '0;
            r_pattern <= '0;
            r_const   <= '0;
        end else begin
            if (w_next_state != r_state) begin
                r_b <= '0;
            end else if (r_state == FRONT || r_state == HBLANK || r_state == VBLANK) begin
                r_b <= r_b + 1'b1;
            end

            if (r_state == ACTIVE && !w_x_last) begin
                r_x <= r_x + 1'b1;
            end else begin
                r_x <= '0;
            end

            if (r_state == HBLANK && w_hb_last) begin
                r_y <= r_y + 1'b1;
            end else if (r_state != ACTIVE && r_state != HBLANK) begin
                r_y <= '0;
            end

            // Configuration is frozen for the whole frame at FRONT entry.
            if (w_next_state == FRONT && r_state != FRONT) begin
                r_pattern <= cfg_pattern;
                r_const   <= cfg_const;
            end
        end
    end

    pfg_pixel_gen #(
        .DATA_W (DATA_W),
        .X_W    (c_x_w),
        .Y_W    (c_y_w)
    ) u_pixel_gen (
        .x         (r_x),
        .y         (r_y),
        .pattern   (r_pattern),
        .const_val (r_const),
        .pixel     (w_pat_pixel)
    );

`ifdef PFG_STAMP_EN
    logic w_first_pix;
    assign w_first_pix = (r_x == '0) && (r_y == '0);
    assign w_pixel     = w_first_pix ? DATA_W'(r_frame_cnt) : w_pat_pixel;
`else
    assign w_pixel = w_pat_pixel;
`endif

    assign w_odata = w_lv ? w_pixel : '0;

    always_ff @(posedge sig_clock or negedge sig_reset_n) begin
        if (!sig_reset_n) begin
            r_odata     <= '0;
            r_lv        <= 1'b0;
            r_fv        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_odata <= w_odata;
            r_lv    <= w_lv;
            r_fv    <= w_fv;
            r_busy  <= w_busy;
            r_done  <= w_frame_end;
            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign odata      = r_odata;
    assign oLValid    = r_lv;
    assign oFValid    = r_fv;
    assign sig_en_o   = r_busy;
    assign frame_done = r_done;
    assign frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pattern_frame_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pattern_frame_gen : directed bench with pixel scoreboard          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pattern_frame_gen;

    localparam int DW   = 12;
    localparam int HA   = 4;
    localparam int HB   = 2;
    localparam int VA   = 3;
    localparam int VB   = 5;
    localparam int FL   = 1;
    localparam int HA16 = 16;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          en     = 1'b0;
    logic          en16   = 1'b0;
    logic [1:0]    pat    = 2'd0;
    logic [1:0]    pat16  = 2'd2;
    logic [DW-1:0] cst    = '0;
    logic [DW-1:0] cst16  = '0;

    logic [DW-1:0] odata, odata16;
    logic          lv, fv, en_o, done;
    logic          lv16, fv16, en_o16, done16;
    logic [15:0]   cnt, cnt16;

    always #5 clk = ~clk;

    pattern_frame_gen #(
        .DATA_W(DW), .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .FV_LEAD(FL)
    ) dut (
        .sig_clock(clk), .sig_reset_n(rst_n), .sig_en_i(en), .cfg_pattern(pat),
        .cfg_const(cst), .odata(odata), .oLValid(lv), .oFValid(fv),
        .sig_en_o(en_o), .frame_done(done), .frame_cnt(cnt)
    );

    pattern_frame_gen #(
        .DATA_W(DW), .H_ACTIVE(HA16), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .FV_LEAD(FL)
    ) dut16 (
        .sig_clock(clk), .sig_reset_n(rst_n), .sig_en_i(en16), .cfg_pattern(pat16),
        .cfg_const(cst16), .odata(odata16), .oLValid(lv16), .oFValid(fv16),
        .sig_en_o(en_o16), .frame_done(done16), .frame_cnt(cnt16)
    );

    int n_asserts = 0;
    int n_fail    = 0;
    logic [DW-1:0] sb_q[$];
    int frames_pushed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_pix(input logic [1:0] p, input logic [DW-1:0] c,
                                                 input int x, input int y, input int fidx);
        logic [31:0] xv;
        logic [31:0] yv;
        logic [31:0] fi;
        xv = x;
        yv = y;
        fi = fidx;
`ifdef PFG_STAMP_EN
        if (x == 0 && y == 0) return fi[DW-1:0];
`endif
        case (p)
            2'd0:    return xv[DW-1:0];
            2'd1:    return yv[DW-1:0];
            2'd2:    return (xv[3] ^ yv[3]) ? {DW{1'b1}} : {DW{1'b0}};
            default: return c;
        endcase
    endfunction

    task automatic push_frame(input logic [1:0] p, input logic [DW-1:0] c);
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++)
                sb_q.push_back(model_pix(p, c, x, y, frames_pushed));
        frames_pushed++;
    endtask

    // Frame-timing monitor and scoreboard consumer for the small instance.
    logic prev_fv = 1'b0, prev_lv = 1'b0;
    int fv_run = 0, low_run = 0, lv_run = 0, gap_run = 0, bursts = 0;
    int frames_seen = 0, last_fv_len = 0, last_low_len = 0, last_period = 0;
    int done_count = 0, cyc = 0, last_rise = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (done) done_count++;
            if (fv && !prev_fv) begin
                if (frames_seen > 0) begin
                    last_low_len = low_run;
                    last_period  = cyc - last_rise;
                end
                last_rise = cyc;
                fv_run    = 0;
                bursts    = 0;
                gap_run   = 0;
            end
            if (!fv && prev_fv) begin
                last_fv_len = fv_run;
                frames_seen++;
                low_run = 0;
                chk("done_on_fv_fall", done, 1);
                chk("lv_bursts", bursts, VA);
            end
            if (fv) fv_run++; else low_run++;
            if (lv && !prev_lv) begin
                chk("lv_gap", gap_run, (bursts == 0) ? FL : HB);
                gap_run = 0;
                bursts++;
                lv_run = 0;
            end
            if (!lv && prev_lv) chk("lv_len", lv_run, HA);
            if (fv && !lv) gap_run++;
            if (lv) begin
                lv_run++;
                n_asserts++;
                assert (sb_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL sb_empty: observed pixel 0x%0h expected no pixel", odata);
                end
                if (sb_q.size() > 0) chk("pixel", odata, sb_q.pop_front());
            end else begin
                chk("odata_idle", odata, 0);
            end
            prev_fv = fv;
            prev_lv = lv;
        end
    end

    task automatic wait_frames(input int target, input int budget);
        int i = 0;
        while (frames_seen < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("frame_timeout", (frames_seen >= target) ? 1 : 0, 1);
    endtask

    task automatic wait_lv(input int budget);
        int i = 0;
        while (!lv && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("lv_timeout", lv, 1);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; pat = 2'd0; cst = '0;
        repeat (3) @(negedge clk);
        chk("rst_odata", odata, 0);
        chk("rst_lv", lv, 0);
        chk("rst_fv", fv, 0);
        chk("rst_en_o", en_o, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", cnt, 0);

        push_frame(2'd0, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("fv_edge1", fv, 0);
        @(posedge clk); #1;
        chk("fv_edge2", fv, 1);
        chk("en_o_busy", en_o, 1);

        wait_frames(1, 100);
        chk("fv_len_f0", last_fv_len, 17);
        chk("cnt_f0", cnt, 1);

        pat = 2'd1;
        push_frame(2'd1, '0);
        wait_frames(2, 100);
        chk("fv_len_f1", last_fv_len, 17);
        chk("fv_low_len", last_low_len, VB);
        chk("period", last_period, 22);
        chk("cnt_f1", cnt, 2);

        pat = 2'd2;
        push_frame(2'd2, '0);
        wait_lv(100);
        pat = 2'd3;
        cst = 12'hABC;
        wait_frames(3, 100);
        chk("cnt_f2", cnt, 3);

        push_frame(2'd3, 12'hABC);
        wait_lv(100);
        repeat (4) @(negedge clk);
        en = 1'b0;
        wait_frames(4, 100);
        chk("fv_len_f3", last_fv_len, 17);
        chk("cnt_f3", cnt, 4);
        chk("done_count", done_count, 4);
        chk("sb_drained", sb_q.size(), 0);
        repeat (8) @(negedge clk);
        chk("idle_en_o", en_o, 0);
        chk("idle_fv", fv, 0);
        repeat (20) @(negedge clk);
        chk("idle_no_frame", frames_seen, 4);
        chk("idle_cnt", cnt, 4);

        en16 = 1'b1;
        for (int i = 0; i < 50 && !lv16; i++) @(negedge clk);
        chk("lv16_timeout", lv16, 1);
        for (int x = 0; x < HA16; x++) begin
            chk("checker_line0", odata16, model_pix(2'd2, '0, x, 0, 0));
            @(negedge clk);
        end
        en16 = 1'b0;

        push_frame(pat, cst);
        en = 1'b1;
        wait_lv(100);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_odata", odata, 0);
        chk("arst_lv", lv, 0);
        chk("arst_fv", fv, 0);
        chk("arst_en_o", en_o, 0);
        chk("arst_cnt", cnt, 0);
        chk("arst_fv16", fv16, 0);
        sb_q.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
